load_use_ctrl: RTL

//  Load-use hazard controller for the ID-stage operand path. Detects a load in EX whose rd feeds the ID instruction.

---
 rtl/load_use_ctrl.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/load_use_ctrl.sv
// ----------------------------------------------------------------------------
// load_use_ctrl
//   Load-use hazard controller for the ID-stage operand path.
//   - Detects a load in EX whose rd is read by the ID instruction. It stalls
//     IF/ID and drops one bubble into EX. The stall is held while data memory
//     is still busy, for at most MAX_WAIT+1 WAIT cycles.
//   - Keeps a 3-slot history of completed load results (s0 = newest) and
//     drives the one-hot slot select plus per-slot operand values consumed by
//     the downstream 3-way load-use mux.
//
//   wb_load_vld is a single-cycle strobe with no back-pressure: a result
//   presented with wb_load_vld=1 and wb_rd!=0 is captured at that rising edge
//   unless flush is high in the same cycle.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   id_rs1/2, id_use1/2  ID source registers and their read enables
//   ex_mem_read, ex_rd   EX-stage load flag and destination
//   mem_busy             data memory has not returned the load yet
//   wb_load_vld          load result valid at WB
//   wb_reg_write         any register write at WB
//   wb_rd, wb_data       WB destination and data
//   flush                pipeline flush
//   fw0_in, fw1_in       normal-forwarding fallback operands
//   stall_if, bubble_ex  hold PC/IF-ID, zero ID/EX control
//   flag0..flag2         one-hot slot select (flag0 = newest)
//   use_jk               operand j value for slot select k
//   timeout_err          sticky WAIT timeout, cleared only by rst
//   state_dbg            current FSM state (0 = IDLE, 1 = WAIT)
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module load_use_ctrl #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            mem_busy,
    input  logic            wb_load_vld,
    input  logic            wb_reg_write,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    input  logic [XLEN-1:0] fw0_in,
    input  logic [XLEN-1:0] fw1_in,
    output logic            stall_if,
    output logic            bubble_ex,
    output logic            flag0,
    output logic            flag1,
    output logic            flag2,
    output logic [XLEN-1:0] use_00,
    output logic [XLEN-1:0] use_01,
    output logic [XLEN-1:0] use_02,
    output logic [XLEN-1:0] use_10,
    output logic [XLEN-1:0] use_11,
    output logic [XLEN-1:0] use_12,
    output logic            timeout_err,
    output logic            state_dbg
);

    localparam int CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          timeout_err_q, timeout_err_d;

    // History slots, index 0 = newest.
    logic [2:0]            vld_q, vld_d;
    logic [2:0][4:0]       rd_q, rd_d;
    logic [2:0][XLEN-1:0]  data_q, data_d;

    logic                  hazard;
    logic                  stall;
    logic [2:0]            m0, m1;
    logic [XLEN-1:0]       v0, v1;
    logic [2:0]            flag;

    assign hazard = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use1 && (ex_rd == id_rs1)) || (id_use2 && (ex_rd == id_rs2)));

    // FSM: IDLE raises the stall combinationally on a hazard; WAIT holds it
    // as a Moore output until memory returns, a flush, or the timeout.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        stall         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hazard && !flush) begin
                    stall = 1'b1;
                    if (mem_busy) state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                stall = 1'b1;
                if (flush || !mem_busy) begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == MAX_CNT) begin
                    state_d       = S_IDLE;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Slot history. A capture shifts in a new s0 even while stalled; without
    // a capture the slots only age when ID advances.
    always_comb begin
        vld_d  = vld_q;
        rd_d   = rd_q;
        data_d = data_q;
        if (flush) begin
            vld_d = '0;
        end else if (wb_load_vld && (wb_rd != 5'd0)) begin
            vld_d  = {vld_q[1:0], 1'b1};
            rd_d   = {rd_q[1:0], wb_rd};
            data_d = {data_q[1:0], wb_data};
        end else if (!stall) begin
            vld_d  = {vld_q[1:0], 1'b0};
            rd_d   = {rd_q[1:0], 5'd0};
            data_d = {data_q[1:0], {XLEN{1'b0}}};
        end
        // A newer non-load write makes any recorded load value stale.
        if (!flush && wb_reg_write && !wb_load_vld) begin
            for (int k = 0; k < 3; k++) begin
                if (rd_d[k] == wb_rd) vld_d[k] = 1'b0;
            end
        end
    end

    // Operand select from the registered slots.
    always_comb begin
        m0 = '0;
        m1 = '0;
        for (int k = 0; k < 3; k++) begin
            m0[k] = vld_q[k] && id_use1 && (id_rs1 != 5'd0) && (rd_q[k] == id_rs1);
            m1[k] = vld_q[k] && id_use2 && (id_rs2 != 5'd0) && (rd_q[k] == id_rs2);
        end
        // Scan oldest to newest so the newest match wins.
        v0 = fw0_in;
        v1 = fw1_in;
        for (int k = 2; k >= 0; k--) begin
            if (m0[k]) v0 = data_q[k];
            if (m1[k]) v1 = data_q[k];
        end
        flag = 3'b000;
        if (!stall) begin
            if (m0[0] || m1[0])      flag = 3'b001;
            else if (m0[1] || m1[1]) flag = 3'b010;
            else if (m0[2] || m1[2]) flag = 3'b100;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
            vld_q         <= '0;
            rd_q          <= '0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
            vld_q         <= vld_d;
            rd_q          <= rd_d;
            data_q        <= data_d;
        end
    end

    assign stall_if    = stall;
    assign bubble_ex   = stall;
    assign flag0       = flag[0];
    assign flag1       = flag[1];
    assign flag2       = flag[2];
    assign use_00      = flag[0] ? v0 : fw0_in;
    assign use_01      = flag[1] ? v0 : fw0_in;
    assign use_02      = flag[2] ? v0 : fw0_in;
    assign use_10      = flag[0] ? v1 : fw1_in;
    assign use_11      = flag[1] ? v1 : fw1_in;
    assign use_12      = flag[2] ? v1 : fw1_in;
    assign timeout_err = timeout_err_q;
    assign state_dbg   = state_q;

endmodule
